// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_PORTS AXI4-Stream byte sources into one
// Ethernet TX stream with an enforced inter-frame gap and truncation at MAX_FRAME_BYTES.
module eth_tx_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned IFG_CYCLES      = 24,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clock,
  input  logic                    aresetn,
  input  logic [8*NUM_PORTS-1:0]  saxis_tdata,
  input  logic [NUM_PORTS-1:0]    saxis_tvalid,
  input  logic [NUM_PORTS-1:0]    saxis_tlast,
  output logic [NUM_PORTS-1:0]    saxis_tready,
  output logic [7:0]              maxis_tdata,
  output logic                    maxis_tvalid,
  output logic                    maxis_tlast,
  input  logic                    maxis_tready,
  output logic [GW-1:0]           grant_port,
  output logic                    busy,
  output logic [16*NUM_PORTS-1:0] frame_count,
  output logic [15:0]             truncated_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam logic [1:0]  S_AFTER = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
  localparam logic [15:0] LIMIT   = 16'(MAX_FRAME_BYTES - 1);
  localparam logic [15:0] IFG_LD  = 16'(IFG_CYCLES);

  logic [1:0]           r_state, w_state_nxt;
  logic [GW-1:0]        r_grant, w_grant_nxt;
  logic [15:0]          r_beat, w_beat_nxt;
  logic [15:0]          r_gap, w_gap_nxt;
  logic [15:0]          r_fcnt [NUM_PORTS];
  logic [15:0]          r_tcnt;
  logic [NUM_PORTS-1:0] w_fc_inc;
  logic                 w_tc_inc;

  logic [7:0]           w_bytes [NUM_PORTS];
  logic [GW-1:0]        w_cand;
  logic [GW-1:0]        w_pick;
  logic                 w_found;
  logic                 w_at_limit;
  logic                 w_src_valid;
  logic                 w_src_last;
  logic                 w_hs_out;
  logic                 w_hs_drain;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ports
    assign w_bytes[p]                = saxis_tdata[8*p +: 8];
    assign frame_count[16*p +: 16]   = r_fcnt[p];
  end

  assign grant_port      = r_grant;
  assign busy            = (r_state != S_IDLE);
  assign truncated_count = r_tcnt;

  assign w_src_valid = saxis_tvalid[r_grant];
  assign w_src_last  = saxis_tlast[r_grant];
  assign w_at_limit  = (r_beat == LIMIT);
  assign w_hs_out    = (r_state == S_GRANT) && w_src_valid && maxis_tready;
  assign w_hs_drain  = (r_state == S_DRAIN) && w_src_valid;

  // Search starts one past the last grant, so the previous winner has lowest priority.
  always_comb begin
    w_pick  = r_grant;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_cand = GW'((32'(r_grant) + k) % NUM_PORTS);
      if (!w_found && saxis_tvalid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    saxis_tready = '0;
    maxis_tdata  = '0;
    maxis_tvalid = 1'b0;
    maxis_tlast  = 1'b0;
    case (r_state)
      S_GRANT: begin
        maxis_tdata           = w_bytes[r_grant];
        maxis_tvalid          = w_src_valid;
        maxis_tlast           = w_src_last | w_at_limit;
        saxis_tready[r_grant] = maxis_tready;
      end
      S_DRAIN: saxis_tready[r_grant] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_fc_inc    = '0;
    w_tc_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_hs_out) begin
          if (w_src_last) begin
            // A source tlast on the limit beat is a normal frame end.
            w_fc_inc[r_grant] = 1'b1;
            w_beat_nxt        = '0;
            w_gap_nxt         = IFG_LD;
            w_state_nxt       = S_AFTER;
          end else if (w_at_limit) begin
            w_fc_inc[r_grant] = 1'b1;
            w_tc_inc          = 1'b1;
            w_beat_nxt        = '0;
            w_state_nxt       = S_DRAIN;
          end else begin
            w_beat_nxt = r_beat + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (w_hs_drain && w_src_last) begin
          w_gap_nxt   = IFG_LD;
          w_state_nxt = S_AFTER;
        end
      end
      default: begin
        w_gap_nxt = r_gap - 16'd1;
        if (r_gap <= 16'd1) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_grant <= GW'(NUM_PORTS - 1);
      r_beat  <= '0;
      r_gap   <= '0;
      r_tcnt  <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_fcnt[p] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
      if (w_tc_inc) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_fc_inc[p]) begin
          r_fcnt[p] <= r_fcnt[p] + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: directed frames per port, expected beats queued at
// issue time and checked by an independent output monitor.
module tb_eth_tx_arbiter;

  localparam int NP   = 2;
  localparam int IFG  = 3;
  localparam int MAXB = 64;

  logic              clock   = 1'b0;
  logic              aresetn = 1'b0;
  logic [8*NP-1:0]   s_tdata  = '0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tlast  = '0;
  logic [NP-1:0]     s_tready;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b1;
  logic              grant_port;
  logic              busy;
  logic [16*NP-1:0]  fcnt;
  logic [15:0]       tcnt;

  eth_tx_arbiter #(
    .NUM_PORTS      (NP),
    .IFG_CYCLES     (IFG),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clock          (clock),
    .aresetn        (aresetn),
    .saxis_tdata    (s_tdata),
    .saxis_tvalid   (s_tvalid),
    .saxis_tlast    (s_tlast),
    .saxis_tready   (s_tready),
    .maxis_tdata    (m_tdata),
    .maxis_tvalid   (m_tvalid),
    .maxis_tlast    (m_tlast),
    .maxis_tready   (m_tready),
    .grant_port     (grant_port),
    .busy           (busy),
    .frame_count    (fcnt),
    .truncated_count(tcnt)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] src_q [NP][$];   // {bubble_before, last, data}
  logic [9:0] sb_q [$];        // {port, last, data}

  int          exp_fc [NP];
  int          exp_tr;
  bit          tog_en      = 1'b0;
  bit          sb_en       = 1'b1;
  bit          chk_gap     = 1'b0;
  bit          have_prev   = 1'b0;
  bit          first_beat  = 1'b1;
  bit          watch_p1    = 1'b0;
  bit          p1_rdy_seen = 1'b0;
  int unsigned last_t      = 0;
  int unsigned hs_total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driver();
    logic [NP-1:0] hs;
    logic [NP-1:0] bub_done;
    logic [9:0]    head;
    bub_done = '0;
    forever begin
      @(negedge clock);
      hs = s_tvalid & s_tready;
      @(posedge clock);
      #1;
      m_tready = tog_en ? ~m_tready : 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p] && src_q[p].size() > 0) begin
          void'(src_q[p].pop_front());
          bub_done[p] = 1'b0;
        end
        if (src_q[p].size() == 0) begin
          s_tvalid[p] = 1'b0;
          s_tlast[p]  = 1'b0;
        end else begin
          head = src_q[p][0];
          if (head[9] && !bub_done[p]) begin
            s_tvalid[p] = 1'b0;
            bub_done[p] = 1'b1;
          end else begin
            s_tvalid[p]          = 1'b1;
            s_tlast[p]           = head[8];
            s_tdata[8*p +: 8]    = head[7:0];
          end
        end
      end
    end
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clock);
      if (watch_p1 && s_tready[1]) p1_rdy_seen = 1'b1;
      if (m_tvalid && m_tready) begin
        hs_total++;
        if (chk_gap && first_beat && have_prev)
          check("ifg_idle_clocks", 32'(cyc - last_t - 1), 32'(IFG + 1));
        first_beat = m_tlast;
        if (m_tlast) begin
          last_t    = cyc;
          have_prev = 1'b1;
          if (grant_port == 1'b0) watch_p1 = 1'b0;
        end
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {m_tlast, m_tdata});
          end else begin
            e = sb_q.pop_front();
            check("out_beat", 32'({grant_port, m_tlast, m_tdata}), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic sync();
    @(negedge clock);
    #1;
  endtask

  // Queue a source frame; when counted, also queue the expected output beats.
  task automatic send(input int p, input logic [7:0] first, input int n, input int bubble_at,
                      input bit counted);
    int out_n;
    out_n = (n > MAXB) ? MAXB : n;
    for (int i = 0; i < n; i++)
      src_q[p].push_back({(i == bubble_at), (i == n - 1), 8'(first + 8'(i))});
    if (counted) begin
      for (int i = 0; i < out_n; i++)
        sb_q.push_back({1'(p), (i == out_n - 1), 8'(first + 8'(i))});
      exp_fc[p]++;
      if (n > MAXB) exp_tr++;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 && !busy)
        done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fc0"}, 32'(fcnt[15:0]), 32'(exp_fc[0]));
    check({tag, "_fc1"}, 32'(fcnt[31:16]), 32'(exp_fc[1]));
    check({tag, "_trunc"}, 32'(tcnt), 32'(exp_tr));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    check({tag, "_tready"}, 32'(s_tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant"}, 32'(grant_port), 32'(NP - 1));
    check({tag, "_fcnt"}, 32'(fcnt), 32'd0);
    check({tag, "_tcnt"}, 32'(tcnt), 32'd0);
  endtask

  initial begin
    int unsigned h0;
    exp_fc = '{default: 0};
    exp_tr = 0;
    fork
      driver();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    #1 aresetn = 1'b1;

    // 1: single 3-byte frame on port 0, then busy timing after tlast
    sync();
    src_q[0].push_back({1'b0, 1'b0, 8'h11});
    src_q[0].push_back({1'b0, 1'b0, 8'h22});
    src_q[0].push_back({1'b0, 1'b1, 8'h33});
    sb_q.push_back({1'b0, 1'b0, 8'h11});
    sb_q.push_back({1'b0, 1'b0, 8'h22});
    sb_q.push_back({1'b0, 1'b1, 8'h33});
    exp_fc[0]++;
    wait_idle("t1_done", 100);
    check("t1_busy_low_delay", 32'(cyc - last_t), 32'(IFG + 1));
    check("t1_grant", 32'(grant_port), 32'd0);
    check_counts("t1");

    // 2: both ports continuously valid, expect P1,P0,P1,P0 with fixed gaps
    repeat (2) @(negedge clock);
    #1;
    have_prev = 1'b0;
    chk_gap   = 1'b1;
    send(1, 8'h50, 4, -1, 1'b1);
    send(0, 8'h40, 4, -1, 1'b1);
    send(1, 8'h54, 4, -1, 1'b1);
    send(0, 8'h44, 4, -1, 1'b1);
    wait_idle("t2_done", 200);
    chk_gap = 1'b0;
    check_counts("t2");

    // 3: 70-byte frame on port 1 truncated to 64 output beats, remainder drained
    sync();
    send(1, 8'h01, 70, -1, 1'b1);
    wait_idle("t3_done", 400);
    check_counts("t3");

    // 4: exactly 64 bytes on port 0, tlast on the limit beat is not a truncation
    sync();
    send(0, 8'hA0, 64, -1, 1'b1);
    wait_idle("t4_done", 400);
    check_counts("t4");

    // 5: downstream ready toggling plus a source bubble; port 1 blocked during port 0 frame
    sync();
    tog_en = 1'b1;
    h0     = hs_total;
    send(0, 8'h61, 6, 2, 1'b1);
    for (int i = 0; i < 100 && hs_total < h0 + 1; i++) @(negedge clock);
    check("t5_started", 32'(hs_total >= h0 + 1), 32'd1);
    #1;
    p1_rdy_seen = 1'b0;
    watch_p1    = 1'b1;
    send(1, 8'h71, 2, -1, 1'b1);
    wait_idle("t5_done", 300);
    tog_en = 1'b0;
    check("t5_p1_blocked", 32'(p1_rdy_seen), 32'd0);
    check_counts("t5");

    // 6: reset mid-frame aborts it; port 0 then wins first again
    sync();
    sb_en = 1'b0;
    h0    = hs_total;
    send(0, 8'hC0, 10, -1, 1'b0);
    for (int i = 0; i < 100 && hs_total < h0 + 3; i++) @(negedge clock);
    check("t6_started", 32'(hs_total >= h0 + 3), 32'd1);
    #1;
    aresetn = 1'b0;
    src_q[0].delete();
    @(negedge clock);
    check_reset_state("t6_abort");
    #1;
    aresetn    = 1'b1;
    first_beat = 1'b1;
    sb_en      = 1'b1;
    exp_fc     = '{default: 0};
    exp_tr     = 0;
    sync();
    send(0, 8'h81, 3, -1, 1'b1);
    send(1, 8'h91, 2, -1, 1'b1);
    wait_idle("t6_done", 200);
    check_counts("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
